// File: rtl/uwasic_onboarding_benjamin_dong_if.sv
// Tile pin bundle: SPI/select inputs in, 16 PWM/static channels and pad enables out.
interface uwasic_onboarding_benjamin_dong_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/uwasic_onboarding_benjamin_dong.sv
// SPI write-only register file (5 regs) driving 16 static/PWM output channels.
// rst_n is an active-high synchronous reset despite its name.
module uwasic_onboarding_benjamin_dong (
    input  logic clk,
    input  logic rst_n,
    uwasic_onboarding_benjamin_dong_if.slave bus
);
    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;
    localparam logic [3:0] PRESC_MAX  = 4'd12;
    localparam logic [6:0] ADDR_MAX   = 7'd4;

    // [0],[1] form the synchronizer; [2] is the previous synchronized sample
    logic [2:0] sclk_q, copi_q, ncs_q;
    logic       sclk_rise, ncs_fall, ncs_rise;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sclk_q <= '0;
            copi_q <= '0;
            ncs_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.ui_in[0]};
            copi_q <= {copi_q[1:0], bus.ui_in[1]};
            ncs_q  <= {ncs_q[1:0],  bus.ui_in[2]};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];
    assign ncs_rise  =  ncs_q[1] & ~ncs_q[2];

    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic        commit;

    // bit_cnt saturates one past the frame length so long frames stay rejected
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (!ncs_q[1] && sclk_rise) begin
            shreg <= {shreg[14:0], copi_q[1]};
            if (bit_cnt != CNT_SAT)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign commit = ncs_rise && (bit_cnt == FRAME_BITS) && shreg[15]
                    && (shreg[14:8] <= ADDR_MAX);

    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (commit) begin
            case (shreg[10:8])
                3'd0:    en_out[7:0]  <= shreg[7:0];
                3'd1:    en_out[15:8] <= shreg[7:0];
                3'd2:    en_pwm[7:0]  <= shreg[7:0];
                3'd3:    en_pwm[15:8] <= shreg[7:0];
                default: duty         <= shreg[7:0];
            endcase
        end
    end

    logic [3:0]  presc;
    logic [7:0]  pc;
    logic        pwm;
    logic [15:0] outs;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            presc <= '0;
            pc    <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            pc    <= pc + 8'd1;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    // 0xFF is forced high so full duty is truly constant, not 255/256
    assign pwm = (duty == 8'hFF) || (pc < duty);

    always_ff @(posedge clk) begin
        if (rst_n) outs <= '0;
        else       outs <= en_out & (~en_pwm | {16{pwm}});
    end

    assign bus.uo_out  = outs[7:0];
    assign bus.uio_out = outs[15:8];
    assign bus.uio_oe  = 8'hFF;

    logic unused_pins;
    assign unused_pins = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};
endmodule

// File: tb/tb_uwasic_onboarding_benjamin_dong.sv
// Directed bench: SPI register writes, rejected frames, PWM timing and reset.
module tb_uwasic_onboarding_benjamin_dong;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uwasic_onboarding_benjamin_dong_if bus ();
    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in  = {5'b0, ncs, copi, sclk};

    uwasic_onboarding_benjamin_dong dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift out the low n bits of 'bits', MSB first, 4 clk per SCLK phase
    task automatic spi_xfer(input logic [31:0] bits, input int n);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
        spi_xfer({16'h0, 1'b1, addr, data}, 16);
    endtask

    // One full PWM period: high count of uo_out[0], cycles where uo_out bits
    // disagree, cycles where uio_out is not 0xFF
    task automatic window(output int hi, output int split, output int uio_bad);
        hi = 0; split = 0; uio_bad = 0;
        for (int i = 0; i < 3328; i++) begin
            @(negedge clk);
            if (bus.uo_out[0]) hi++;
            if (bus.uo_out != 8'h00 && bus.uo_out != 8'hFF) split++;
            if (bus.uio_out != 8'hFF) uio_bad++;
        end
    endtask

    task automatic period(output int per);
        logic prev;
        int   n;
        per = -1;
        prev = bus.uo_out[0];
        n = 0;
        while (n < 4000 && !(prev == 1'b0 && bus.uo_out[0] == 1'b1)) begin
            prev = bus.uo_out[0];
            @(negedge clk);
            n++;
        end
        if (n < 4000) begin
            n = 0;
            prev = bus.uo_out[0];
            do begin
                prev = bus.uo_out[0];
                @(negedge clk);
                n++;
            end while (n < 4000 && !(prev == 1'b0 && bus.uo_out[0] == 1'b1));
            if (n < 4000) per = n;
        end
    endtask

    initial begin
        int hi, split, ubad, per;

        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_uo_out", bus.uo_out, 8'h00);
        chk("reset_uio_out", bus.uio_out, 8'h00);
        chk("reset_uio_oe", bus.uio_oe, 8'hFF);
        repeat (4) @(negedge clk);

        spi_write(7'h00, 8'hF0);
        chk("static_uo_out", bus.uo_out, 8'hF0);
        spi_write(7'h01, 8'hCC);
        chk("static_uio_out", bus.uio_out, 8'hCC);

        spi_xfer(32'h0000_00FF, 16);
        chk("read_frame", bus.uo_out, 8'hF0);
        spi_xfer(32'h0000_B0FF, 16);
        chk("bad_addr_uo", bus.uo_out, 8'hF0);
        chk("bad_addr_uio", bus.uio_out, 8'hCC);
        spi_xfer(32'h0000_407F, 15);
        chk("short_frame", bus.uo_out, 8'hF0);
        spi_xfer(32'h0001_80FF, 17);
        chk("long_frame", bus.uo_out, 8'hF0);
        spi_write(7'h05, 8'hFF);
        chk("addr5_frame", bus.uo_out, 8'hF0);

        spi_write(7'h00, 8'h01);
        spi_write(7'h02, 8'h01);
        spi_write(7'h04, 8'h80);
        window(hi, split, ubad);
        chk("pwm50_high", hi, 1664);
        period(per);
        chk("pwm50_period", per, 3328);
        chk("pwm50_uio_static", bus.uio_out, 8'hCC);

        spi_write(7'h04, 8'h00);
        window(hi, split, ubad);
        chk("duty00_high", hi, 0);
        spi_write(7'h04, 8'hFF);
        window(hi, split, ubad);
        chk("dutyFF_high", hi, 3328);

        spi_write(7'h00, 8'hFF);
        spi_write(7'h01, 8'hFF);
        spi_write(7'h02, 8'hFF);
        spi_write(7'h03, 8'h00);
        spi_write(7'h04, 8'h40);
        window(hi, split, ubad);
        chk("mixed_high", hi, 832);
        chk("mixed_uo_together", split, 0);
        chk("mixed_uio_const", ubad, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_uo_out", bus.uo_out, 8'h00);
        chk("midrst_uio_out", bus.uio_out, 8'h00);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_write(7'h00, 8'hAA);
        chk("post_rst_write", bus.uo_out, 8'hAA);
        chk("post_rst_uio", bus.uio_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
